// File: rtl/mac_seq_ctrl.sv
// Dot-product sequencer around an external combinational MAC: loads a job,
// folds vec_len operand pairs into a registered accumulator, then offers the sum.
module mac_seq_ctrl #(
  parameter int BIT_WIDTH = 8,
  parameter int OUT_WIDTH = 32,
  parameter int LEN_WIDTH = 8
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 start,
  input  logic [LEN_WIDTH-1:0] vec_len,
  input  logic [OUT_WIDTH-1:0] bias,
  input  logic                 abort,
  output logic                 busy,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [BIT_WIDTH-1:0] weight_in,
  input  logic [BIT_WIDTH-1:0] inp_in,
  output logic [BIT_WIDTH-1:0] mac_weight,
  output logic [BIT_WIDTH-1:0] mac_inp,
  output logic [OUT_WIDTH-1:0] mac_psum_in,
  input  logic [OUT_WIDTH-1:0] mac_psum_out,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [OUT_WIDTH-1:0] result
);

  typedef enum logic [1:0] {
    IDLE,
    ACCUM,
    OUTPUT
  } state_t;

  state_t               state;
  logic [OUT_WIDTH-1:0] acc;
  logic [LEN_WIDTH-1:0] cnt;
  logic                 fire;

  // NOTE: handshake outputs decode the state register directly but are gated
  // by abort in the same cycle, so a cancelled cycle never accepts or presents.
  assign busy      = (state != IDLE);
  assign in_ready  = (state == ACCUM) && !abort;
  assign out_valid = (state == OUTPUT) && !abort;
  assign result    = out_valid ? acc : '0;
  assign fire      = in_valid && in_ready;

  assign mac_weight  = weight_in;
  assign mac_inp     = inp_in;
  assign mac_psum_in = acc;

  // NOTE: all state uses non-blocking assignments so every register samples
  // the pre-edge values of its peers, independent of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      acc   <= '0;
      cnt   <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (start && !abort) begin
            acc   <= bias;
            cnt   <= vec_len;
            state <= (vec_len == '0) ? OUTPUT : ACCUM;
          end
        end
        ACCUM: begin
          if (abort) begin
            state <= IDLE;
            acc   <= '0;
            cnt   <= '0;
          end else if (fire) begin
            acc <= mac_psum_out;
            cnt <= cnt - LEN_WIDTH'(1);
            if (cnt == LEN_WIDTH'(1)) state <= OUTPUT;
          end
        end
        OUTPUT: begin
          if (abort) begin
            state <= IDLE;
            acc   <= '0;
            cnt   <= '0;
          end else if (out_ready) begin
            state <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mac_seq_ctrl.sv
// Self-checking bench for mac_seq_ctrl: exact MAC in the loop, a job-level
// reference model checked every cycle, plus hand-computed result pins.
module tb_mac_seq_ctrl;

  localparam int BW = 8;
  localparam int OW = 32;
  localparam int LW = 8;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          start = 1'b0;
  logic [LW-1:0] vec_len = '0;
  logic [OW-1:0] bias = '0;
  logic          abort = 1'b0;
  logic          busy;
  logic          in_valid = 1'b0;
  logic          in_ready;
  logic [BW-1:0] weight_in = '0;
  logic [BW-1:0] inp_in = '0;
  logic [BW-1:0] mac_weight;
  logic [BW-1:0] mac_inp;
  logic [OW-1:0] mac_psum_in;
  logic [OW-1:0] mac_psum_out;
  logic          out_valid;
  logic          out_ready = 1'b0;
  logic [OW-1:0] result;

  int tests = 0;
  int failed = 0;

  always #5 clk = ~clk;

  // Exact MAC: sum + weight*inp, wrapping at OW bits.
  assign mac_psum_out = mac_psum_in + (OW'(mac_weight) * OW'(mac_inp));

  mac_seq_ctrl #(.BIT_WIDTH(BW), .OUT_WIDTH(OW), .LEN_WIDTH(LW)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .vec_len(vec_len), .bias(bias),
    .abort(abort), .busy(busy), .in_valid(in_valid), .in_ready(in_ready),
    .weight_in(weight_in), .inp_in(inp_in), .mac_weight(mac_weight),
    .mac_inp(mac_inp), .mac_psum_in(mac_psum_in), .mac_psum_out(mac_psum_out),
    .out_valid(out_valid), .out_ready(out_ready), .result(result)
  );

  task automatic check(input string name, input logic [OW-1:0] act, input logic [OW-1:0] exp);
    tests++;
    if (act !== exp) begin
      failed++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h at %0t", name, act, exp, $time);
    end
  endtask

  // Job-level model: is a job collecting operands, how many remain, the
  // running sum, and whether a finished sum is waiting for the consumer.
  bit            m_collect = 1'b0;
  bit            m_hold = 1'b0;
  int unsigned   m_left = 0;
  logic [OW-1:0] m_sum = '0;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_collect = 1'b0;
      m_hold    = 1'b0;
      m_left    = 0;
      m_sum     = '0;
    end else if (!m_collect && !m_hold) begin
      if (start && !abort) begin
        m_sum  = bias;
        m_left = int'(vec_len);
        if (m_left == 0) m_hold = 1'b1;
        else m_collect = 1'b1;
      end
    end else if (abort) begin
      m_collect = 1'b0;
      m_hold    = 1'b0;
      m_sum     = '0;
    end else if (m_collect) begin
      if (in_valid) begin
        m_sum  = m_sum + OW'(weight_in) * OW'(inp_in);
        m_left = m_left - 1;
        if (m_left == 0) begin
          m_collect = 1'b0;
          m_hold    = 1'b1;
        end
      end
    end else if (out_ready) begin
      m_hold = 1'b0;
    end
  end

  always @(negedge clk) begin
    check("model busy", OW'(busy), OW'(m_collect || m_hold));
    check("model in_ready", OW'(in_ready), OW'(m_collect && !abort));
    check("model out_valid", OW'(out_valid), OW'(m_hold && !abort));
    check("model result", result, (m_hold && !abort) ? m_sum : '0);
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic launch(input logic [LW-1:0] len, input logic [OW-1:0] b);
    start = 1'b1; vec_len = len; bias = b;
    tick();
    start = 1'b0; vec_len = '0; bias = '0;
  endtask

  task automatic feed(input logic [BW-1:0] w, input logic [BW-1:0] x);
    in_valid = 1'b1; weight_in = w; inp_in = x;
    tick();
    in_valid = 1'b0; weight_in = '0; inp_in = '0;
  endtask

  task automatic expect_result(input string name, input logic [OW-1:0] exp);
    check({name, " out_valid"}, OW'(out_valid), 32'd1);
    check({name, " result"}, result, exp);
  endtask

  task automatic consume();
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    #12;
    check("reset busy", OW'(busy), 32'd0);
    check("reset in_ready", OW'(in_ready), 32'd0);
    check("reset out_valid", OW'(out_valid), 32'd0);
    check("reset result", result, 32'd0);
    rst_n = 1'b1;
    tick();

    // 1: full-throughput job, 10 + 6 + 20 + 1 = 37.
    launch(8'd3, 32'd10);
    check("t1 in_ready", OW'(in_ready), 32'd1);
    in_valid = 1'b1;
    weight_in = 8'd2; inp_in = 8'd3; tick();
    weight_in = 8'd4; inp_in = 8'd5; tick();
    weight_in = 8'd1; inp_in = 8'd1; tick();
    in_valid = 1'b0;
    expect_result("t1", 32'd37);
    consume();
    check("t1 busy after", OW'(busy), 32'd0);

    // 2: empty vector returns bias the cycle after start.
    launch(8'd0, 32'hDEADBEEF);
    check("t2 in_ready", OW'(in_ready), 32'd0);
    expect_result("t2", 32'hDEADBEEF);
    consume();

    // 3: bubbly input, held output; 4 * 255 * 255 = 260100.
    launch(8'd4, 32'd0);
    for (int i = 0; i < 8; i++) begin
      in_valid = (i % 2 == 0); weight_in = 8'd255; inp_in = 8'd255;
      tick();
    end
    in_valid = 1'b0;
    for (int i = 0; i < 5; i++) begin
      expect_result("t3 held", 32'd260100);
      tick();
    end
    consume();
    check("t3 busy after", OW'(busy), 32'd0);

    // 4: wrap via the MAC, and a start during ACCUM must not reload cnt.
    launch(8'd1, 32'hFFFFFFFF);
    start = 1'b1; vec_len = 8'd9; bias = 32'd123;
    tick();
    start = 1'b0; vec_len = '0; bias = '0;
    check("t4 still accum", OW'(in_ready), 32'd1);
    feed(8'd1, 8'd1);
    expect_result("t4", 32'h00000000);
    consume();

    // 5: abort after two fires, then a clean job: 7 + 9 = 16.
    launch(8'd5, 32'd0);
    feed(8'd1, 8'd1);
    feed(8'd2, 8'd2);
    abort = 1'b1; in_valid = 1'b1; weight_in = 8'd5; inp_in = 8'd5;
    #2;
    check("t5 in_ready on abort", OW'(in_ready), 32'd0);
    tick();
    abort = 1'b0; in_valid = 1'b0;
    check("t5 idle after abort", OW'(busy), 32'd0);
    for (int i = 0; i < 3; i++) begin
      check("t5 no result", OW'(out_valid), 32'd0);
      tick();
    end
    launch(8'd1, 32'd7);
    feed(8'd3, 8'd3);
    expect_result("t5", 32'd16);
    consume();

    // 6: async reset mid-ACCUM, then a fresh job: 1 + 4 + 9 = 14.
    launch(8'd3, 32'd100);
    feed(8'd1, 8'd1);
    in_valid = 1'b1; weight_in = 8'd2; inp_in = 8'd2;
    #2;
    rst_n = 1'b0;
    #1;
    check("t6 busy in reset", OW'(busy), 32'd0);
    check("t6 in_ready in reset", OW'(in_ready), 32'd0);
    check("t6 out_valid in reset", OW'(out_valid), 32'd0);
    check("t6 result in reset", result, 32'd0);
    in_valid = 1'b0;
    @(negedge clk);
    #2;
    rst_n = 1'b1;
    tick();
    launch(8'd2, 32'd1);
    feed(8'd2, 8'd2);
    feed(8'd3, 8'd3);
    expect_result("t6", 32'd14);
    consume();
    tick();

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule

// File: doc/mac_seq_ctrl.md
Name: mac_seq_ctrl

Overview:
Sequencer that drives one combinational MAC datapath (weight, inp, partial_sum_in -> partial_sum_out) to compute a full dot product.
- Accepts a job (vector length plus bias) on a start pulse.
- Streams weight/input pairs in through a valid/ready handshake, folding each into a registered accumulator via the MAC.
- Presents the final sum through a valid/ready output.
- Sits between the operand buffers and the exact or approximate MAC instance; the MAC itself is external.

Parameters:
BIT_WIDTH, 8, operand width of weight and input
OUT_WIDTH, 32, accumulator / partial-sum width
LEN_WIDTH, 8, width of vector-length field (max 2^LEN_WIDTH-1 elements)

Ports:
clk  input  1  clock, rising-edge
rst_n  input  1  asynchronous active-low reset
start  input  1  job launch pulse; sampled only in IDLE
vec_len  input  LEN_WIDTH  number of element pairs in job; sampled with start
bias  input  OUT_WIDTH  initial accumulator value; sampled with start
abort  input  1  synchronous job cancel
busy  output  1  high in any state except IDLE
in_valid  input  1  operand pair valid
in_ready  output  1  controller accepts operand pair
weight_in  input  BIT_WIDTH  operand weight
inp_in  input  BIT_WIDTH  operand input
mac_weight  output  BIT_WIDTH  to MAC weight
mac_inp  output  BIT_WIDTH  to MAC inp
mac_psum_in  output  OUT_WIDTH  to MAC partial_sum_in
mac_psum_out  input  OUT_WIDTH  from MAC partial_sum_out
out_valid  output  1  result valid
out_ready  input  1  downstream accepts result
result  output  OUT_WIDTH  dot-product result

Behaviour:
- Reset (rst_n low, async): state=IDLE, acc=0, cnt=0. Outputs: busy=0, in_ready=0, out_valid=0, result=0.
- States are IDLE, ACCUM and OUTPUT.
- IDLE:
  - start=1 loads acc<=bias and cnt<=vec_len.
  - If vec_len==0, next state is OUTPUT; else ACCUM.
- ACCUM:
  - in_ready=1.
  - Fire = in_valid & in_ready.
  - On fire: acc<=mac_psum_out, cnt<=cnt-1. If cnt==1, next state is OUTPUT.
  - No fire: hold.
  - Exactly vec_len fires per job; one element per cycle at full throughput.
- MAC drive (combinational, all states):
  - mac_weight=weight_in, mac_inp=inp_in, mac_psum_in=acc.
  - The MAC result is captured only on fire.
- OUTPUT:
  - out_valid=1, result=acc, in_ready=0.
  - On out_ready, next state is IDLE.
  - result holds stable while out_valid=1 and out_ready=0.
  - result is 0 whenever out_valid=0.
- Latency: the result is valid in the cycle after the last fire. For vec_len==0, it is valid in the cycle after start.
- Arithmetic: the controller performs no arithmetic on the sum. Wrap-around and signedness are the MAC's. acc stores mac_psum_out verbatim at OUT_WIDTH.
- start while busy: ignored; no effect on acc or cnt.
- abort=1 in any non-IDLE state: next state is IDLE and acc=0.
  - The operand pair presented with abort is not accepted (in_ready forced 0 that cycle).
  - A pending result is dropped (out_valid forced 0 that cycle).
- abort in IDLE: no effect. abort together with start in IDLE: abort wins, job not launched.
- in_valid outside ACCUM: ignored (in_ready=0).
- Async reset mid-job: immediately returns to reset values. The job is lost with no partial output.
- Back-to-back jobs: start may be asserted in the first IDLE cycle after the output handshake.

Test Plan:
1. Reset then start with vec_len=3, bias=10, pairs (2,3),(4,5),(1,1) fed with in_valid held high and exact MAC model -> three fires in 3 consecutive cycles; out_valid next cycle with result=10+6+20+1=37; busy=0 after out_ready.
2. vec_len=0, bias=0xDEADBEEF -> out_valid the cycle after start, result=0xDEADBEEF, in_ready never asserted.
3. vec_len=4, bias=0, all pairs (255,255), in_valid toggling 1/0 each cycle, out_ready held low 5 cycles -> exactly 4 fires; result=260100 held stable until out_ready.
4. bias=0xFFFFFFFF, vec_len=1, pair (1,1) -> result=0x00000000 (wrap via MAC); start pulsed during ACCUM is ignored and cnt is unchanged.
5. vec_len=5: abort after the 2nd fire -> IDLE next cycle, no out_valid. A new job (vec_len=1, bias=7, pair (3,3)) then yields result=16.
6. rst_n pulled low mid-ACCUM (asynchronously, between clock edges) -> busy, in_ready and out_valid drop immediately; result=0. After release, a fresh job completes correctly.
